multi_cycle_control: RTL and testbench

//  Main control FSM of the multi-cycle RV32I core. It sits upstream of the register file and

---
 rtl/multi_cycle_control_if.sv | 38 +++
 rtl/multi_cycle_control.sv | 178 +++++++++++++++++
 tb/tb_multi_cycle_control.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_control_if.sv
// Control-path bundle between the multi-cycle control FSM and the datapath / memory / register file.
// mem_read/mem_write are the request valid; mem_ready completes it. A request is held unchanged
// until a rising clk edge sees mem_ready=1, and the FSM moves on at that edge.
interface multi_cycle_control_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       is_halted;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       is_ecall;
  logic       halted;
  logic       mem_error;
  logic [2:0] fsm_state;

  modport master (
    input  opcode, mem_ready, is_halted,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, is_ecall, halted,
           mem_error, fsm_state
  );

  modport slave (
    output opcode, mem_ready, is_halted,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, is_ecall, halted,
           mem_error, fsm_state
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle RV32I core: sequences IF/ID/EX/MEM/WB with a memory
// ready handshake and stops on halt, illegal opcode or memory timeout.
module multi_cycle_control #(
  parameter int MEM_WAIT_MAX = 16
) (
  input logic                   clk,
  input logic                   reset,
  multi_cycle_control_if.master bus
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   wait_cnt, wait_cnt_d;
  logic            active;
  logic            mem_error_q;
  logic            legal;
  logic            waiting;
  logic            timeout;

  always_comb begin
    case (bus.opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // A wait cycle is one where a memory request is out and not completed; the limit-th such
  // cycle without mem_ready is the timeout, while mem_ready in that cycle still completes.
  assign waiting    = active && (state == S_IF || state == S_MEM) && !bus.mem_ready;
  assign timeout    = waiting && (wait_cnt == CW'(MEM_WAIT_MAX - 1));
  assign wait_cnt_d = (waiting && !timeout) ? wait_cnt + 1'b1 : '0;

  // active stays low through reset and the following cycle so strobes start one cycle after release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IF;
      wait_cnt    <= '0;
      active      <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      state       <= state_d;
      wait_cnt    <= wait_cnt_d;
      active      <= 1'b1;
      mem_error_q <= mem_error_q | timeout;
    end
  end

  always_comb begin
    state_d           = state;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_source     = 2'd0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 2'd0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'd0;
    bus.alu_op        = 2'd0;
    bus.is_ecall      = 1'b0;
    if (active) begin
      case (state)
        S_IF: begin
          bus.mem_read = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            state_d      = S_ID;
          end else if (timeout) begin
            state_d = S_HALT;
          end
        end
        S_ID: begin
          bus.alu_src_b = 2'd2;
          if (bus.opcode == OP_ECALL) begin
            bus.is_ecall = 1'b1;
            if (bus.is_halted) begin
              state_d = S_HALT;
            end else begin
              bus.pc_write = 1'b1;
              state_d      = S_IF;
            end
          end else if (legal) begin
            state_d = S_EX;
          end else begin
            state_d = S_HALT;
          end
        end
        S_EX: begin
          case (bus.opcode)
            OP_R: begin
              bus.alu_src_a = 1'b1;
              bus.alu_op    = 2'd2;
              state_d       = S_WB;
            end
            OP_I: begin
              bus.alu_src_a = 1'b1;
              bus.alu_src_b = 2'd1;
              bus.alu_op    = 2'd2;
              state_d       = S_WB;
            end
            OP_LOAD, OP_STORE: begin
              bus.alu_src_a = 1'b1;
              bus.alu_src_b = 2'd1;
              state_d       = S_MEM;
            end
            OP_BRANCH: begin
              bus.alu_src_a     = 1'b1;
              bus.alu_op        = 2'd1;
              bus.pc_write_cond = 1'b1;
              bus.pc_source     = 2'd1;
              state_d           = S_IF;
            end
            OP_JAL, OP_JALR: state_d = S_WB;
            default: state_d = S_HALT;
          endcase
        end
        S_MEM: begin
          bus.i_or_d    = 1'b1;
          bus.mem_read  = (bus.opcode == OP_LOAD);
          bus.mem_write = (bus.opcode != OP_LOAD);
          if (bus.mem_ready) begin
            if (bus.opcode == OP_LOAD) begin
              state_d = S_WB;
            end else begin
              bus.pc_write = 1'b1;
              state_d      = S_IF;
            end
          end else if (timeout) begin
            state_d = S_HALT;
          end
        end
        S_WB: begin
          bus.reg_write = 1'b1;
          bus.pc_write  = 1'b1;
          case (bus.opcode)
            OP_LOAD: bus.mem_to_reg = 2'd1;
            OP_JAL: begin
              bus.mem_to_reg = 2'd2;
              bus.pc_source  = 2'd1;
            end
            OP_JALR: begin
              bus.mem_to_reg = 2'd2;
              bus.pc_source  = 2'd2;
            end
            default: bus.mem_to_reg = 2'd0;
          endcase
          state_d = S_IF;
        end
        S_HALT: state_d = S_HALT;
        default: state_d = S_HALT;
      endcase
    end
  end

  assign bus.halted    = (state == S_HALT);
  assign bus.mem_error = mem_error_q;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: instruction-level reference model expands each instruction into
// its expected per-cycle strobe sequence; directed table, random instructions and a mid-MEM reset.
module tb_multi_cycle_control;
  localparam int MEM_WAIT_MAX = 16;
  localparam int W = 19;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       is_ecall;
    logic       halted;
    logic       mem_error;
  } outs_t;

  typedef struct {
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       is_halted;
    string      tag;
  } vec_t;

  typedef struct {
    logic [6:0] op;
    int         if_w;
    int         mem_w;
    bit         hlt;
    string      name;
  } dir_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_cycle_control_if bus ();
  multi_cycle_control #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // scoreboard
  vec_t           vec_q[$];
  logic [W-1:0]   exp_q[$];
  int             checks = 0;
  int             errors = 0;

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(logic rst_n, logic [6:0] op, logic rdy, logic hlt, outs_t o,
                               string tag);
    vec_t v;
    v.rst_n = rst_n; v.opcode = op; v.mem_ready = rdy; v.is_halted = hlt; v.tag = tag;
    vec_q.push_back(v);
    exp_q.push_back(o);
  endfunction

  function automatic void push_halt(logic [6:0] op, logic err, string name);
    outs_t o;
    for (int i = 0; i < 3; i++) begin
      o = '0; o.halted = 1'b1; o.mem_error = err;
      push(1'b1, op, rnd_bit(), rnd_bit(), o, {name, "_halt"});
    end
  endfunction

  function automatic void push_reset(string name);
    push(1'b0, 7'd0, 1'b0, 1'b0, outs_t'('0), {name, "_rst"});
    push(1'b1, 7'd0, 1'b0, 1'b0, outs_t'('0), {name, "_release"});
  endfunction

  // Reference model: one instruction -> its cycle-by-cycle expected strobes. Returns 1 if it halts.
  function automatic bit build_instr(logic [6:0] op, int if_w, int mem_w, bit hlt, string name);
    outs_t o;
    bit ld = (op == OP_LOAD);
    bit st = (op == OP_STORE);
    bit legal = op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL};
    for (int i = 0; i < if_w && i < MEM_WAIT_MAX; i++) begin
      o = '0; o.mem_read = 1'b1;
      push(1'b1, op, 1'b0, rnd_bit(), o, {name, "_if_wait"});
    end
    if (if_w >= MEM_WAIT_MAX) begin
      push_halt(op, 1'b1, name);
      return 1'b1;
    end
    o = '0; o.mem_read = 1'b1; o.ir_write = 1'b1;
    push(1'b1, op, 1'b1, rnd_bit(), o, {name, "_if"});
    o = '0; o.alu_src_b = 2'd2;
    if (op == OP_ECALL) begin
      o.is_ecall = 1'b1; o.pc_write = !hlt;
      push(1'b1, op, rnd_bit(), hlt, o, {name, "_id"});
      if (hlt) push_halt(op, 1'b0, name);
      return hlt;
    end
    push(1'b1, op, rnd_bit(), rnd_bit(), o, {name, "_id"});
    if (!legal) begin
      push_halt(op, 1'b0, name);
      return 1'b1;
    end
    o = '0;
    case (op)
      OP_R:      begin o.alu_src_a = 1'b1; o.alu_op = 2'd2; end
      OP_I:      begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd1; o.alu_op = 2'd2; end
      OP_LOAD,
      OP_STORE:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd1; end
      OP_BRANCH: begin
        o.alu_src_a = 1'b1; o.alu_op = 2'd1; o.pc_write_cond = 1'b1; o.pc_source = 2'd1;
      end
      default: ;
    endcase
    push(1'b1, op, rnd_bit(), rnd_bit(), o, {name, "_ex"});
    if (op == OP_BRANCH) return 1'b0;
    if (ld || st) begin
      for (int i = 0; i < mem_w && i < MEM_WAIT_MAX; i++) begin
        o = '0; o.i_or_d = 1'b1; o.mem_read = ld; o.mem_write = st;
        push(1'b1, op, 1'b0, rnd_bit(), o, {name, "_mem_wait"});
      end
      if (mem_w >= MEM_WAIT_MAX) begin
        push_halt(op, 1'b1, name);
        return 1'b1;
      end
      o = '0; o.i_or_d = 1'b1; o.mem_read = ld; o.mem_write = st; o.pc_write = st;
      push(1'b1, op, 1'b1, rnd_bit(), o, {name, "_mem"});
      if (st) return 1'b0;
    end
    o = '0; o.reg_write = 1'b1; o.pc_write = 1'b1;
    if (ld) o.mem_to_reg = 2'd1;
    if (op == OP_JAL)  begin o.mem_to_reg = 2'd2; o.pc_source = 2'd1; end
    if (op == OP_JALR) begin o.mem_to_reg = 2'd2; o.pc_source = 2'd2; end
    push(1'b1, op, rnd_bit(), rnd_bit(), o, {name, "_wb"});
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] sample();
    outs_t o;
    o.pc_write = bus.pc_write;     o.pc_write_cond = bus.pc_write_cond;
    o.pc_source = bus.pc_source;   o.i_or_d = bus.i_or_d;
    o.mem_read = bus.mem_read;     o.mem_write = bus.mem_write;
    o.ir_write = bus.ir_write;     o.mem_to_reg = bus.mem_to_reg;
    o.reg_write = bus.reg_write;   o.alu_src_a = bus.alu_src_a;
    o.alu_src_b = bus.alu_src_b;   o.alu_op = bus.alu_op;
    o.is_ecall = bus.is_ecall;     o.halted = bus.halted;
    o.mem_error = bus.mem_error;
    return o;
  endfunction

  task automatic check(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: inputs change on negedge, outputs checked 1ns later
  task automatic run_queue();
    vec_t         v;
    logic [W-1:0] e;
    while (vec_q.size() > 0) begin
      v = vec_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      reset = v.rst_n;
      bus.opcode = v.opcode;
      bus.mem_ready = v.mem_ready;
      bus.is_halted = v.is_halted;
      #1;
      check(v.tag, sample(), e);
    end
  endtask

  dir_t       dir_tab[14];
  logic [6:0] legal_ops[8];
  outs_t      o;

  initial begin
    reset = 1'b0;
    bus.opcode = '0; bus.mem_ready = 1'b0; bus.is_halted = 1'b0;
    legal_ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL};
    dir_tab[0]  = '{OP_R,      0, 0, 1'b0, "add"};
    dir_tab[1]  = '{OP_I,      1, 0, 1'b0, "addi"};
    dir_tab[2]  = '{OP_LOAD,   0, 3, 1'b0, "lw_wait3"};
    dir_tab[3]  = '{OP_STORE,  0, 1, 1'b0, "sw"};
    dir_tab[4]  = '{OP_BRANCH, 0, 0, 1'b0, "beq"};
    dir_tab[5]  = '{OP_JAL,    0, 0, 1'b0, "jal"};
    dir_tab[6]  = '{OP_JALR,   2, 0, 1'b0, "jalr"};
    dir_tab[7]  = '{OP_ECALL,  0, 0, 1'b0, "ecall_run"};
    dir_tab[8]  = '{OP_R,      MEM_WAIT_MAX - 1, 0, 1'b0, "if_limit_ok"};
    dir_tab[9]  = '{OP_LOAD,   0, MEM_WAIT_MAX - 1, 1'b0, "mem_limit_ok"};
    dir_tab[10] = '{OP_ECALL,  0, 0, 1'b1, "ecall_halt"};
    dir_tab[11] = '{7'b0000000, 0, 0, 1'b0, "illegal"};
    dir_tab[12] = '{OP_R,      MEM_WAIT_MAX, 0, 1'b0, "if_timeout"};
    dir_tab[13] = '{OP_STORE,  0, MEM_WAIT_MAX, 1'b0, "mem_timeout"};

    repeat (2) @(posedge clk);
    push_reset("init");
    foreach (dir_tab[i]) begin
      if (build_instr(dir_tab[i].op, dir_tab[i].if_w, dir_tab[i].mem_w, dir_tab[i].hlt,
                      dir_tab[i].name))
        push_reset(dir_tab[i].name);
    end
    run_queue();

    for (int n = 0; n < 80; n++) begin
      logic [6:0] op;
      int         iw, mw;
      op = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 7)] : 7'($urandom);
      iw = ($urandom_range(0, 19) == 0) ? $urandom_range(MEM_WAIT_MAX - 1, MEM_WAIT_MAX)
                                        : $urandom_range(0, 3);
      mw = ($urandom_range(0, 19) == 0) ? $urandom_range(MEM_WAIT_MAX - 1, MEM_WAIT_MAX)
                                        : $urandom_range(0, 3);
      if (build_instr(op, iw, mw, ($urandom_range(0, 3) == 0), "rnd"))
        push_reset("rnd");
    end
    run_queue();

    // store caught in MEM by reset: request must drop without waiting for a clock edge
    o = '0; o.mem_read = 1'b1; o.ir_write = 1'b1;
    push(1'b1, OP_STORE, 1'b1, 1'b0, o, "mid_if");
    o = '0; o.alu_src_b = 2'd2;
    push(1'b1, OP_STORE, 1'b0, 1'b0, o, "mid_id");
    o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'd1;
    push(1'b1, OP_STORE, 1'b0, 1'b0, o, "mid_ex");
    o = '0; o.i_or_d = 1'b1; o.mem_write = 1'b1;
    push(1'b1, OP_STORE, 1'b0, 1'b0, o, "mid_mem_wait");
    run_queue();
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    check("mid_mem_held", sample(), o);
    reset = 1'b0;
    #1;
    check("reset_drops_mem_write", sample(), '0);
    push(1'b1, OP_R, 1'b0, 1'b0, outs_t'('0), "mid_release");
    void'(build_instr(OP_R, 0, 0, 1'b0, "after_mid_reset"));
    run_queue();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
